acp_cmd_arbiter: RTL and testbench
==================================

ACP_CMD_ARBITER -- requirements
Module: acp_cmd_arbiter

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 72, datamover command width.
REQ-002 SHALL have parameter STS_WIDTH, default 8, datamover status width.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, maximum outstanding commands; power of two, at least 2.
REQ-004 SHALL have clk, input, 1, single clock for all logic.
REQ-005 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have s0_cmd_tdata/tvalid/tready, in/in/out, CMD_WIDTH/1/1, requester 0 command stream (s2h master).
REQ-007 SHALL have s1_cmd_tdata/tvalid/tready, in/in/out, CMD_WIDTH/1/1, requester 1 command stream (h2s master).
REQ-008 SHALL have m_cmd_tdata/tvalid/tready, out/out/in, CMD_WIDTH/1/1, shared datamover command port.
REQ-009 SHALL have m_sts_tdata/tvalid/tready, in/in/out, STS_WIDTH/1/1, shared datamover status port.
REQ-010 SHALL have s0_sts_tdata/tvalid/tready and s1_sts_tdata/tvalid/tready, out/out/in, STS_WIDTH/1/1, per-requester status returns.
REQ-011 SHALL have outstanding, output, log2(TAG_DEPTH)+1, number of issued commands awaiting status.
REQ-012 SHALL have grant_cnt0 and grant_cnt1, output, 32 each, per-requester issued-command counters (see Configuration).

Function
REQ-013 SHALL implement FSM with states IDLE and ISSUE.
REQ-014 In IDLE with at least one cmd_tvalid and outstanding < TAG_DEPTH, SHALL select a requester, assert that requester's cmd_tready for exactly that cycle, register its tdata and ID, and enter ISSUE.
REQ-015 In IDLE with outstanding == TAG_DEPTH, SHALL keep both cmd_tready low and stay in IDLE.
REQ-016 With both requesters valid, SHALL grant the one not granted last (round-robin); after reset, requester 0 has priority.
REQ-017 In ISSUE, SHALL hold m_cmd_tvalid=1 and m_cmd_tdata stable until m_cmd_tready; on that handshake SHALL push the granted ID into the tag FIFO and return to IDLE.
REQ-018 SHALL keep both s*_cmd_tready low while in ISSUE; minimum command spacing is 2 cycles.
REQ-019 SHALL route m_sts_tdata/tvalid to the requester at the tag FIFO head; the other requester's sts_tvalid SHALL be 0.
REQ-020 m_sts_tready SHALL equal the head requester's sts_tready when the FIFO is non-empty, else 0; status arriving with empty FIFO SHALL stall, never drop.
REQ-021 SHALL pop the tag FIFO on m_sts_tvalid && m_sts_tready.
REQ-022 Push and pop in the same cycle SHALL leave outstanding unchanged; FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-023 Command-path latency: m_cmd_tvalid asserts the cycle after the requester handshake; status path is combinational (zero latency).

Reset
REQ-024 On rst, SHALL asynchronously enter IDLE, clear tag FIFO, set outstanding=0, round-robin priority to requester 0, grant_cnt0/1=0.
REQ-025 During and after reset, all tready/tvalid outputs SHALL be 0 and m_cmd_tdata 0; a command in ISSUE at reset is discarded.

Configuration
REQ-026 With macro ACP_ARB_STATS_EN defined, grant_cnt0/1 SHALL increment by 1 on each m_cmd handshake for the corresponding requester, wrapping from 32'hFFFFFFFF to 0.
REQ-027 Without ACP_ARB_STATS_EN, grant_cnt0/1 SHALL be tied to 0 and no counter registers synthesised; all other behaviour unchanged.

Verification
REQ-028 Single: s0 issues cmd 72'h1_0000_1000_0000_0040, m_cmd_tready=1 -> m_cmd_tvalid one cycle after s0 handshake with identical data; status 8'h80 returns on s0_sts only; outstanding 0->1->0.
REQ-029 Contention: s0 and s1 valid continuously for 6 commands -> grant order 0,1,0,1,0,1; with ACP_ARB_STATS_EN grant_cnt0=grant_cnt1=3.
REQ-030 Backpressure: m_cmd_tready low 5 cycles in ISSUE -> m_cmd_tdata stable, both s*_cmd_tready low throughout.
REQ-031 Full: issue 4 commands with m_sts_tvalid=0 -> outstanding=4, 5th request not accepted until a status pops, then accepted next IDLE cycle.
REQ-032 Ordering/stall: issue s1,s0; s1_sts_tready=0 -> m_sts_tready=0, s0 receives nothing until s1 completes; simultaneous push/pop keeps outstanding constant.
REQ-033 Reset mid-ISSUE: assert rst while m_cmd_tvalid=1 -> outputs 0 immediately, outstanding=0, next grant goes to s0 when both valid.

Source files
------------

// File: rtl/acp_cmd_arbiter_if.sv
// Stream bundle between two datamover requesters, the shared datamover and acp_cmd_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface acp_cmd_arbiter_if #(
    parameter int CMD_WIDTH = 72,
    parameter int STS_WIDTH = 8
);
    logic [CMD_WIDTH-1:0] s0_cmd_tdata;
    logic                 s0_cmd_tvalid;
    logic                 s0_cmd_tready;
    logic [CMD_WIDTH-1:0] s1_cmd_tdata;
    logic                 s1_cmd_tvalid;
    logic                 s1_cmd_tready;

    logic [CMD_WIDTH-1:0] m_cmd_tdata;
    logic                 m_cmd_tvalid;
    logic                 m_cmd_tready;

    logic [STS_WIDTH-1:0] m_sts_tdata;
    logic                 m_sts_tvalid;
    logic                 m_sts_tready;

    logic [STS_WIDTH-1:0] s0_sts_tdata;
    logic                 s0_sts_tvalid;
    logic                 s0_sts_tready;
    logic [STS_WIDTH-1:0] s1_sts_tdata;
    logic                 s1_sts_tvalid;
    logic                 s1_sts_tready;

    modport slave (
        input  s0_cmd_tdata, s0_cmd_tvalid, output s0_cmd_tready,
        input  s1_cmd_tdata, s1_cmd_tvalid, output s1_cmd_tready,
        output m_cmd_tdata, m_cmd_tvalid,   input  m_cmd_tready,
        input  m_sts_tdata, m_sts_tvalid,   output m_sts_tready,
        output s0_sts_tdata, s0_sts_tvalid, input  s0_sts_tready,
        output s1_sts_tdata, s1_sts_tvalid, input  s1_sts_tready
    );

    modport master (
        output s0_cmd_tdata, s0_cmd_tvalid, input  s0_cmd_tready,
        output s1_cmd_tdata, s1_cmd_tvalid, input  s1_cmd_tready,
        input  m_cmd_tdata, m_cmd_tvalid,   output m_cmd_tready,
        output m_sts_tdata, m_sts_tvalid,   input  m_sts_tready,
        input  s0_sts_tdata, s0_sts_tvalid, output s0_sts_tready,
        input  s1_sts_tdata, s1_sts_tvalid, output s1_sts_tready
    );
endinterface

// File: rtl/acp_cmd_arbiter.sv
// Round-robin arbiter sharing one datamover between two requesters; a tag FIFO routes statuses back in issue order.
// Optional per-requester grant counters are enabled by defining ACP_ARB_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a requester command while fewer than TAG_DEPTH are outstanding
// ISSUE | presenting the registered command on m_cmd until the datamover accepts it
module acp_cmd_arbiter #(
    parameter int CMD_WIDTH = 72,
    parameter int STS_WIDTH = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    acp_cmd_arbiter_if.slave             bus,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic [31:0]                  grant_cnt0,
    output logic [31:0]                  grant_cnt1
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_nxt;
    logic [CMD_WIDTH-1:0] cmd_reg;
    logic                 cmd_id;
    logic                 prio1;
    logic                 grant0, grant1;

    logic                 tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 push, pop, full, empty, head;

    assign full  = (outstanding == CNT_W'(TAG_DEPTH));
    assign empty = (outstanding == '0);
    assign head  = tag_mem[rd_ptr];
    assign push  = (state == ISSUE) && bus.m_cmd_tready;
    assign pop   = bus.m_sts_tvalid && bus.m_sts_tready;

    // rst gates the grant so cmd_tready stays low while reset is held.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !full) begin
                    if (bus.s0_cmd_tvalid && bus.s1_cmd_tvalid) begin
                        grant1 = prio1;
                        grant0 = !prio1;
                    end else begin
                        grant0 = bus.s0_cmd_tvalid;
                        grant1 = bus.s1_cmd_tvalid;
                    end
                    if (grant0 || grant1) state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_cmd_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cmd_reg <= '0;
            cmd_id  <= 1'b0;
            prio1   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                cmd_reg <= grant1 ? bus.s1_cmd_tdata : bus.s0_cmd_tdata;
                cmd_id  <= grant1;
                prio1   <= grant0;
            end
        end
    end

    assign bus.s0_cmd_tready = grant0;
    assign bus.s1_cmd_tready = grant1;
    assign bus.m_cmd_tvalid  = (state == ISSUE);
    assign bus.m_cmd_tdata   = cmd_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= cmd_id;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Status goes only to the requester owning the oldest outstanding command.
    assign bus.m_sts_tready  = !empty && (head ? bus.s1_sts_tready : bus.s0_sts_tready);
    assign bus.s0_sts_tvalid = !empty && !head && bus.m_sts_tvalid;
    assign bus.s1_sts_tvalid = !empty &&  head && bus.m_sts_tvalid;
    assign bus.s0_sts_tdata  = (!empty && !head) ? bus.m_sts_tdata : '0;
    assign bus.s1_sts_tdata  = (!empty &&  head) ? bus.m_sts_tdata : '0;

`ifdef ACP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (push) begin
            if (cmd_id) grant_cnt1 <= grant_cnt1 + 32'd1;
            else        grant_cnt0 <= grant_cnt0 + 32'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_acp_cmd_arbiter.sv
// Scoreboard bench for acp_cmd_arbiter: expected commands/statuses are queued at stimulus time
// and a negedge monitor pops and compares them on every output handshake.
module tb_acp_cmd_arbiter;
    localparam int CW = 72;
    localparam int SW = 8;
    localparam int TD = 4;
`ifdef ACP_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [2:0]    outstanding;
    logic [31:0]   grant_cnt0, grant_cnt1;

    acp_cmd_arbiter_if #(.CMD_WIDTH(CW), .STS_WIDTH(SW)) bus ();

    acp_cmd_arbiter #(.CMD_WIDTH(CW), .STS_WIDTH(SW), .TAG_DEPTH(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
    );

    int tests = 0;
    int fails = 0;

    logic [CW-1:0] s0_q[$], s1_q[$], exp_cmd_q[$];
    logic [SW-1:0] exp_sts0_q[$], exp_sts1_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Requester drivers: present queue heads, advance on handshake.
    initial begin
        logic hs0, hs1;
        bus.s0_cmd_tvalid = 1'b0;
        bus.s0_cmd_tdata  = '0;
        bus.s1_cmd_tvalid = 1'b0;
        bus.s1_cmd_tdata  = '0;
        forever begin
            @(negedge clk);
            hs0 = bus.s0_cmd_tvalid && bus.s0_cmd_tready;
            hs1 = bus.s1_cmd_tvalid && bus.s1_cmd_tready;
            @(posedge clk);
            #1;
            if (hs0 && s0_q.size() > 0) void'(s0_q.pop_front());
            if (hs1 && s1_q.size() > 0) void'(s1_q.pop_front());
            bus.s0_cmd_tvalid = (s0_q.size() > 0);
            bus.s0_cmd_tdata  = (s0_q.size() > 0) ? s0_q[0] : '0;
            bus.s1_cmd_tvalid = (s1_q.size() > 0);
            bus.s1_cmd_tdata  = (s1_q.size() > 0) ? s1_q[0] : '0;
        end
    end

    // Monitor.
    initial begin
        logic [CW-1:0] ec;
        logic [SW-1:0] es;
        forever begin
            @(negedge clk);
            if (bus.m_cmd_tvalid && bus.m_cmd_tready) begin
                check("cmd_expected", CW'(exp_cmd_q.size() != 0), CW'(1));
                if (exp_cmd_q.size() != 0) begin
                    ec = exp_cmd_q.pop_front();
                    check("cmd_data", bus.m_cmd_tdata, ec);
                end
            end
            if (bus.s0_sts_tvalid && bus.s0_sts_tready) begin
                check("sts0_expected", CW'(exp_sts0_q.size() != 0), CW'(1));
                if (exp_sts0_q.size() != 0) begin
                    es = exp_sts0_q.pop_front();
                    check("sts0_data", CW'(bus.s0_sts_tdata), CW'(es));
                end
            end
            if (bus.s1_sts_tvalid && bus.s1_sts_tready) begin
                check("sts1_expected", CW'(exp_sts1_q.size() != 0), CW'(1));
                if (exp_sts1_q.size() != 0) begin
                    es = exp_sts1_q.pop_front();
                    check("sts1_data", CW'(bus.s1_sts_tdata), CW'(es));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input bit which, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? (bus.s1_cmd_tvalid && bus.s1_cmd_tready)
                           : (bus.s0_cmd_tvalid && bus.s0_cmd_tready)) && n < 100);
        check({name, "_hs_in_time"}, CW'(n < 100), CW'(1));
    endtask

    task automatic wait_out(input int val, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(outstanding == 3'(val) && !bus.m_cmd_tvalid &&
                     s0_q.size() == 0 && s1_q.size() == 0) && n < 300);
        check({name, "_settle_in_time"}, CW'(n < 300), CW'(1));
    endtask

    task automatic send_sts(input logic [SW-1:0] d);
        int n = 0;
        cyc();
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_sts_tready && n < 200);
        check("sts_accept_in_time", CW'(n < 200), CW'(1));
        cyc();
        bus.m_sts_tvalid = 1'b0;
        bus.m_sts_tdata  = '0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.m_cmd_tready  = 1'b1;
        bus.m_sts_tvalid  = 1'b0;
        bus.m_sts_tdata   = '0;
        bus.s0_sts_tready = 1'b1;
        bus.s1_sts_tready = 1'b1;

        @(negedge clk);
        check("rst_m_cmd_tvalid", CW'(bus.m_cmd_tvalid), CW'(0));
        check("rst_m_cmd_tdata", bus.m_cmd_tdata, '0);
        check("rst_outstanding", CW'(outstanding), CW'(0));
        check("rst_m_sts_tready", CW'(bus.m_sts_tready), CW'(0));
        check("rst_grant_cnt0", CW'(grant_cnt0), CW'(0));
        cyc();
        cyc();
        rst = 1'b0;

        // Contention: both valid continuously, expect 0,1,0,1,0,1.
        cyc();
        for (int i = 0; i < 3; i++) begin
            s0_q.push_back(CW'(72'hA0 + i));
            s1_q.push_back(CW'(72'hB0 + i));
        end
        for (int i = 0; i < 3; i++) begin
            exp_cmd_q.push_back(CW'(72'hA0 + i));
            exp_cmd_q.push_back(CW'(72'hB0 + i));
            exp_sts0_q.push_back(SW'(8'h10 + 2 * i));
            exp_sts1_q.push_back(SW'(8'h11 + 2 * i));
        end
        for (int i = 0; i < 6; i++) send_sts(SW'(8'h10 + i));
        wait_out(0, "contention");
        check("contention_grant_cnt0", CW'(grant_cnt0), STATS ? CW'(3) : CW'(0));
        check("contention_grant_cnt1", CW'(grant_cnt1), STATS ? CW'(3) : CW'(0));

        // Single command and status on s0.
        cyc();
        s0_q.push_back(72'h1_0000_1000_0000_0040);
        exp_cmd_q.push_back(72'h1_0000_1000_0000_0040);
        wait_hs(1'b0, "single");
        check("single_out_before", CW'(outstanding), CW'(0));
        @(negedge clk);
        check("single_m_cmd_tvalid_latency", CW'(bus.m_cmd_tvalid), CW'(1));
        @(negedge clk);
        check("single_out_issued", CW'(outstanding), CW'(1));
        exp_sts0_q.push_back(8'h80);
        cyc();
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = 8'h80;
        @(negedge clk);
        check("single_s0_sts_tvalid", CW'(bus.s0_sts_tvalid), CW'(1));
        check("single_s1_sts_tvalid", CW'(bus.s1_sts_tvalid), CW'(0));
        cyc();
        bus.m_sts_tvalid = 1'b0;
        bus.m_sts_tdata  = '0;
        @(negedge clk);
        check("single_out_after", CW'(outstanding), CW'(0));

        // Backpressure on m_cmd for 5 cycles.
        cyc();
        bus.m_cmd_tready = 1'b0;
        s0_q.push_back(72'hC3C3);
        exp_cmd_q.push_back(72'hC3C3);
        wait_hs(1'b0, "bp");
        cyc();
        s1_q.push_back(72'hD3D3);
        exp_cmd_q.push_back(72'hD3D3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_cmd_tvalid", CW'(bus.m_cmd_tvalid), CW'(1));
            check("bp_m_cmd_tdata", bus.m_cmd_tdata, 72'hC3C3);
            check("bp_s0_cmd_tready", CW'(bus.s0_cmd_tready), CW'(0));
            check("bp_s1_cmd_tready", CW'(bus.s1_cmd_tready), CW'(0));
        end
        cyc();
        bus.m_cmd_tready = 1'b1;
        exp_sts0_q.push_back(8'h21);
        exp_sts1_q.push_back(8'h22);
        send_sts(8'h21);
        send_sts(8'h22);
        wait_out(0, "bp");

        // Full tag FIFO: 5th command waits for a status pop.
        cyc();
        for (int i = 0; i < 5; i++) begin
            s0_q.push_back(CW'(72'hE0 + i));
            exp_cmd_q.push_back(CW'(72'hE0 + i));
            exp_sts0_q.push_back(SW'(8'h30 + i));
        end
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (outstanding != 3'd4 && n < 100);
            check("full_reached_in_time", CW'(n < 100), CW'(1));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_outstanding", CW'(outstanding), CW'(4));
            check("full_s0_cmd_tready", CW'(bus.s0_cmd_tready), CW'(0));
        end
        send_sts(8'h30);
        @(negedge clk);
        check("full_out_after_pop", CW'(outstanding), CW'(3));
        check("full_5th_accepted", CW'(bus.s0_cmd_tready), CW'(1));
        for (int i = 1; i < 5; i++) send_sts(SW'(8'h30 + i));
        wait_out(0, "full");

        // Ordering and stall: s1 head blocks s0's status.
        cyc();
        bus.s1_sts_tready = 1'b0;
        s1_q.push_back(72'hF1);
        s0_q.push_back(72'hF0);
        exp_cmd_q.push_back(72'hF1);
        exp_cmd_q.push_back(72'hF0);
        wait_out(2, "order");
        exp_sts1_q.push_back(8'h41);
        cyc();
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = 8'h41;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_m_sts_tready", CW'(bus.m_sts_tready), CW'(0));
            check("stall_s0_sts_tvalid", CW'(bus.s0_sts_tvalid), CW'(0));
            check("stall_s1_sts_tvalid", CW'(bus.s1_sts_tvalid), CW'(1));
        end
        cyc();
        bus.s1_sts_tready = 1'b1;
        bus.m_cmd_tready  = 1'b0;
        @(negedge clk);
        check("stall_release_m_sts_tready", CW'(bus.m_sts_tready), CW'(1));
        cyc();
        bus.m_sts_tvalid = 1'b0;
        bus.m_sts_tdata  = '0;
        @(negedge clk);
        check("order_out_after_s1", CW'(outstanding), CW'(1));

        // Push and pop in the same cycle.
        s0_q.push_back(72'h6060);
        exp_cmd_q.push_back(72'h6060);
        wait_hs(1'b0, "pushpop");
        cyc();
        bus.m_cmd_tready = 1'b1;
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = 8'h40;
        exp_sts0_q.push_back(8'h40);
        @(negedge clk);
        check("pushpop_both_handshake",
              CW'({bus.m_cmd_tvalid && bus.m_cmd_tready, bus.m_sts_tvalid && bus.m_sts_tready}),
              CW'(2'b11));
        check("pushpop_out_before", CW'(outstanding), CW'(1));
        cyc();
        bus.m_sts_tvalid = 1'b0;
        bus.m_sts_tdata  = '0;
        @(negedge clk);
        check("pushpop_out_after", CW'(outstanding), CW'(1));
        exp_sts0_q.push_back(8'h42);
        send_sts(8'h42);
        wait_out(0, "pushpop");

        // Reset while a command is held in ISSUE.
        cyc();
        s0_q.push_back(72'h7071);
        exp_cmd_q.push_back(72'h7071);
        wait_out(1, "rstmid_pre");
        cyc();
        bus.m_cmd_tready = 1'b0;
        s0_q.push_back(72'h7072);
        s0_q.push_back(72'h7073);
        wait_hs(1'b0, "rstmid");
        @(negedge clk);
        check("rstmid_holding", CW'(bus.m_cmd_tvalid), CW'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_m_cmd_tvalid", CW'(bus.m_cmd_tvalid), CW'(0));
        check("rstmid_m_cmd_tdata", bus.m_cmd_tdata, '0);
        check("rstmid_outstanding", CW'(outstanding), CW'(0));
        check("rstmid_s0_cmd_tready", CW'(bus.s0_cmd_tready), CW'(0));
        check("rstmid_grant_cnt0", CW'(grant_cnt0), CW'(0));
        s0_q.delete();
        cyc();
        cyc();
        rst = 1'b0;
        bus.m_cmd_tready = 1'b1;
        s1_q.push_back(72'h8081);
        s0_q.push_back(72'h8080);
        exp_cmd_q.push_back(72'h8080);
        exp_cmd_q.push_back(72'h8081);
        exp_sts0_q.push_back(8'h50);
        exp_sts1_q.push_back(8'h51);
        send_sts(8'h50);
        send_sts(8'h51);
        wait_out(0, "post_rst");
        check("post_rst_grant_cnt0", CW'(grant_cnt0), STATS ? CW'(1) : CW'(0));
        check("post_rst_grant_cnt1", CW'(grant_cnt1), STATS ? CW'(1) : CW'(0));

        cyc();
        check("end_cmd_queue_empty", CW'(exp_cmd_q.size()), CW'(0));
        check("end_sts0_queue_empty", CW'(exp_sts0_q.size()), CW'(0));
        check("end_sts1_queue_empty", CW'(exp_sts1_q.size()), CW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
